// File: rtl/packet_detector_if.sv
// Envelope-detector handshake bundle: enable and raw comparator in,
// packet window and detection strobe out.
interface packet_detector_if;
    logic i_en;
    logic i_comp_in;
    logic o_dec_out;
    logic o_det_stb;

    modport master (
        output i_en,
        output i_comp_in,
        input  o_dec_out,
        input  o_det_stb
    );

    modport slave (
        input  i_en,
        input  i_comp_in,
        output o_dec_out,
        output o_det_stb
    );
endinterface

// File: rtl/packet_detector.sv
// Preamble detector: synchronises and deglitches the comparator, validates
// NUM_PULSES high/low widths, then holds the packet window for HOLD_LEN cycles.
module packet_detector #(
    parameter int FILT_LEN   = 4,
    parameter int PULSE_MIN  = 180,
    parameter int PULSE_MAX  = 220,
    parameter int GAP_MIN    = 180,
    parameter int GAP_MAX    = 220,
    parameter int NUM_PULSES = 4,
    parameter int HOLD_LEN   = 1000,
    parameter int CNT_W      = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    packet_detector_if.slave    io_pd
);

    localparam int FC_W = $clog2(FILT_LEN + 1);
    localparam int PC_W = $clog2(NUM_PULSES + 1);

    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(NUM_PULSES - 1);
    localparam logic [CNT_W-1:0] W_PMIN  = CNT_W'(PULSE_MIN);
    localparam logic [CNT_W-1:0] W_PMAX  = CNT_W'(PULSE_MAX);
    localparam logic [CNT_W-1:0] W_GMIN  = CNT_W'(GAP_MIN);
    localparam logic [CNT_W-1:0] W_GMAX  = CNT_W'(GAP_MAX);
    localparam logic [CNT_W-1:0] W_HOLD  = CNT_W'(HOLD_LEN);
    localparam logic [CNT_W-1:0] W_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_HOLD
    } state_t;

    logic             r_s1;
    logic             r_s2;
    logic             r_lvl;
    logic             r_lvl_prev;
    logic [FC_W-1:0]  r_fc;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_wc;
    logic [CNT_W-1:0] w_wc_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic             r_dec_out;
    logic             r_det_stb;

    logic             w_rise;
    logic             w_fall;

    // Front end keeps running while disabled so a re-enable sees a settled level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_lvl      <= 1'b0;
            r_lvl_prev <= 1'b0;
            r_fc       <= '0;
        end else begin
            r_s1       <= io_pd.i_comp_in;
            r_s2       <= r_s1;
            r_lvl_prev <= r_lvl;
            if (r_s2 != r_lvl) begin
                if (r_fc == FC_LAST) begin
                    r_lvl <= ~r_lvl;
                    r_fc  <= '0;
                end else begin
                    r_fc <= r_fc + FC_W'(1);
                end
            end else begin
                r_fc <= '0;
            end
        end
    end

    assign w_rise = r_lvl & ~r_lvl_prev;
    assign w_fall = ~r_lvl & r_lvl_prev;

    always_comb begin
        w_state_next = r_state;
        w_wc_next    = r_wc;
        w_pc_next    = r_pc;
        if (!io_pd.i_en) begin
            w_state_next = ST_IDLE;
            w_wc_next    = '0;
            w_pc_next    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_next = ST_HIGH;
                        w_wc_next    = W_ONE;
                        w_pc_next    = '0;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        if (r_wc >= W_PMIN && r_wc <= W_PMAX) begin
                            w_wc_next = W_ONE;
                            if (r_pc == PC_LAST) begin
                                w_state_next = ST_HOLD;
                            end else begin
                                w_state_next = ST_LOW;
                                w_pc_next    = r_pc + PC_W'(1);
                            end
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else if (r_wc >= W_PMAX) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_wc_next = r_wc + W_ONE;
                    end
                end
                ST_LOW: begin
                    // A short gap restarts the count with this edge as pulse one.
                    if (w_rise) begin
                        w_state_next = ST_HIGH;
                        w_wc_next    = W_ONE;
                        if (r_wc < W_GMIN) begin
                            w_pc_next = '0;
                        end
                    end else if (r_wc >= W_GMAX) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_wc_next = r_wc + W_ONE;
                    end
                end
                ST_HOLD: begin
                    if (r_wc >= W_HOLD) begin
                        w_state_next = ST_IDLE;
                        w_wc_next    = '0;
                        w_pc_next    = '0;
                    end else begin
                        w_wc_next = r_wc + W_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_wc_next    = '0;
                    w_pc_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_wc      <= '0;
            r_pc      <= '0;
            r_dec_out <= 1'b0;
            r_det_stb <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_wc      <= w_wc_next;
            r_pc      <= w_pc_next;
            r_dec_out <= (w_state_next == ST_HOLD);
            r_det_stb <= (w_state_next == ST_HOLD) && (r_state != ST_HOLD);
        end
    end

    assign io_pd.o_dec_out = r_dec_out;
    assign io_pd.o_det_stb = r_det_stb;

endmodule

// File: tb/tb_packet_detector.sv
// Self-checking bench: segment-level stimulus (random and directed) compared
// against a run-length preamble model of the detector.
module tb_packet_detector;

    localparam int FILT_LEN   = 4;
    localparam int PULSE_MIN  = 180;
    localparam int PULSE_MAX  = 220;
    localparam int GAP_MIN    = 180;
    localparam int GAP_MAX    = 220;
    localparam int NUM_PULSES = 4;
    localparam int HOLD_LEN   = 1000;
    localparam int CNT_W      = 16;
    // Negedge index of first DEC_OUT high relative to the negedge driving the final fall.
    localparam int LAT        = FILT_LEN + 3;

    logic clk = 1'b0;
    logic rst;
    packet_detector_if pd_if();

    packet_detector #(
        .FILT_LEN(FILT_LEN), .PULSE_MIN(PULSE_MIN), .PULSE_MAX(PULSE_MAX),
        .GAP_MIN(GAP_MIN), .GAP_MAX(GAP_MAX), .NUM_PULSES(NUM_PULSES),
        .HOLD_LEN(HOLD_LEN), .CNT_W(CNT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_pd (pd_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic prev_dec = 1'b0;
    logic prev_lvl = 1'b0;
    int   rise_tot = 0;
    int   stb_tot  = 0;
    int   tog_tot  = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   stb_cyc  = 0;

    always @(negedge clk) begin
        prev_dec <= pd_if.o_dec_out;
        prev_lvl <= dut.r_lvl;
        if (pd_if.o_dec_out && !prev_dec) begin
            rise_tot <= rise_tot + 1;
            rise_cyc <= cyc;
        end
        if (!pd_if.o_dec_out && prev_dec) fall_cyc <= cyc;
        if (pd_if.o_det_stb) begin
            stb_tot <= stb_tot + 1;
            stb_cyc <= cyc;
        end
        if (dut.r_lvl != prev_lvl) tog_tot <= tog_tot + 1;
    end

    logic seg_lv[64];
    int   seg_w[64];
    bit   seg_gl[64];
    int   seg_start[64];
    int   n_seg;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic seg_add(input logic lv, input int w, input bit gl);
        seg_lv[n_seg] = lv;
        seg_w[n_seg]  = w;
        seg_gl[n_seg] = gl;
        n_seg++;
    endtask

    task automatic seg_clear();
        n_seg = 0;
        seg_add(1'b0, 50, 1'b0);
    endtask

    task automatic add_pulses(input int n, input int hw, input int lw, input bit gl);
        for (int i = 0; i < n; i++) begin
            seg_add(1'b1, hw, gl);
            if (i < n - 1) seg_add(1'b0, lw, gl);
        end
    endtask

    // Count consecutive in-range pulses; an out-of-range gap after a counted
    // pulse (or any bad pulse) starts the count over. Returns index of the
    // segment whose start is the detecting fall, or -1.
    function automatic int model_detect();
        int count = 0;
        for (int i = 0; i < n_seg; i++) begin
            if (seg_lv[i]) begin
                if (seg_w[i] >= PULSE_MIN && seg_w[i] <= PULSE_MAX) count++;
                else count = 0;
                if (count == NUM_PULSES) return i + 1;
            end else if (count > 0 && (seg_w[i] < GAP_MIN || seg_w[i] > GAP_MAX)) begin
                count = 0;
            end
        end
        return -1;
    endfunction

    task automatic drive_segs(input int from, input int to);
        for (int i = from; i < to; i++) begin
            for (int j = 0; j < seg_w[i]; j++) begin
                @(negedge clk);
                if (j == 0) seg_start[i] = cyc;
                if (seg_gl[i] && j >= seg_w[i] / 2 && j < seg_w[i] / 2 + 3)
                    pd_if.i_comp_in = ~seg_lv[i];
                else
                    pd_if.i_comp_in = seg_lv[i];
            end
        end
    endtask

    task automatic run_trial(input string name);
        int det;
        int r0;
        int s0;
        int t0;
        int exp_tog;
        int exp_rise;
        det = model_detect();
        if (det >= 0) begin
            n_seg = det;
            seg_add(1'b0, HOLD_LEN + 40, 1'b0);
        end else begin
            seg_add(1'b0, GAP_MAX + 80, 1'b0);
        end
        exp_tog = 0;
        for (int i = 1; i < n_seg; i++)
            if (seg_lv[i] != seg_lv[i-1]) exp_tog++;
        @(negedge clk);
        r0 = rise_tot;
        s0 = stb_tot;
        t0 = tog_tot;
        drive_segs(0, n_seg);
        @(negedge clk);
        if (det >= 0) begin
            exp_rise = seg_start[det] + LAT;
            chk({name, "_rises"},    rise_tot - r0, 1);
            chk({name, "_rise_cyc"}, rise_cyc, exp_rise);
            chk({name, "_hold_len"}, fall_cyc - rise_cyc, HOLD_LEN);
            chk({name, "_stb_cnt"},  stb_tot - s0, 1);
            chk({name, "_stb_cyc"},  stb_cyc, exp_rise);
        end else begin
            chk({name, "_rises"},   rise_tot - r0, 0);
            chk({name, "_stb_cnt"}, stb_tot - s0, 0);
        end
        chk({name, "_lvl_tog"}, tog_tot - t0, exp_tog);
        $display("trial %s: segs=%0d det_seg=%0d dec_rises=%0d", name, n_seg, det, rise_tot - r0);
    endtask

    task automatic pick_w(output int w, output bit gl);
        int r;
        int b;
        r  = $urandom_range(0, 11);
        gl = 1'b0;
        w  = $urandom_range(PULSE_MIN, PULSE_MAX);
        case (r)
            7:  gl = 1'b1;
            8: begin
                b = $urandom_range(0, 3);
                case (b)
                    0: w = 179;
                    1: w = 180;
                    2: w = 220;
                    default: w = 221;
                endcase
            end
            9:  w = $urandom_range(120, 179);
            10: w = $urandom_range(221, 260);
            default: ;
        endcase
    endtask

    task automatic en_test();
        int r0;
        int s0;
        int st;
        seg_clear();
        add_pulses(4, 200, 200, 1'b0);
        @(negedge clk);
        r0 = rise_tot;
        s0 = stb_tot;
        drive_segs(0, n_seg);
        st = 0;
        for (int j = 0; j < 1600; j++) begin
            @(negedge clk);
            if (j == 0) st = cyc;
            pd_if.i_comp_in = 1'b0;
            pd_if.i_en = (cyc == st + LAT + 499) ? 1'b0 : 1'b1;
        end
        pd_if.i_en = 1'b1;
        @(negedge clk);
        chk("en_rises",    rise_tot - r0, 1);
        chk("en_rise_cyc", rise_cyc, st + LAT);
        chk("en_high_len", fall_cyc - rise_cyc, 500);
        chk("en_stb_cnt",  stb_tot - s0, 1);
        $display("trial en_cut: dec high %0d cycles before enable drop", fall_cyc - rise_cyc);
        seg_clear();
        add_pulses(4, 200, 200, 1'b0);
        run_trial("en_rearm");
    endtask

    task automatic rst_test();
        int waited;
        // Reset while the FSM is measuring a gap.
        seg_clear();
        seg_add(1'b1, 200, 1'b0);
        seg_add(1'b0, 100, 1'b0);
        drive_segs(0, n_seg);
        #2 rst = 1'b1;
        #1 chk("rst_low_dec", int'(pd_if.o_dec_out), 0);
        chk("rst_low_lvl", int'(dut.r_lvl), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset while the window is open.
        seg_clear();
        add_pulses(4, 200, 200, 1'b0);
        seg_add(1'b0, 20, 1'b0);
        drive_segs(0, n_seg);
        waited = 0;
        while (!pd_if.o_dec_out && waited < 100) begin
            @(negedge clk);
            pd_if.i_comp_in = 1'b0;
            waited++;
        end
        chk("rst_hold_pre_dec", int'(pd_if.o_dec_out), 1);
        repeat (200) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_hold_dec", int'(pd_if.o_dec_out), 0);
        chk("rst_hold_stb", int'(pd_if.o_det_stb), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        $display("trial rst: async reset in gap and in window");
        seg_clear();
        add_pulses(2, 200, 200, 1'b0);
        seg_add(1'b0, 300, 1'b0);
        add_pulses(4, 200, 200, 1'b0);
        run_trial("rst_after");
    endtask

    initial begin
        int np;
        int w;
        bit gl;
        rst = 1'b1;
        pd_if.i_en = 1'b1;
        pd_if.i_comp_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dec", int'(pd_if.o_dec_out), 0);
        chk("reset_stb", int'(pd_if.o_det_stb), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        seg_clear(); add_pulses(4, 200, 200, 1'b0); run_trial("nominal");
        seg_clear(); add_pulses(4, 200, 200, 1'b1); run_trial("glitch");

        seg_clear(); add_pulses(3, 200, 200, 1'b0); seg_add(1'b0, 200, 1'b0);
        seg_add(1'b1, 179, 1'b0); run_trial("pulse179");

        seg_clear();
        seg_add(1'b1, 180, 1'b0); seg_add(1'b0, 200, 1'b0);
        seg_add(1'b1, 220, 1'b0); seg_add(1'b0, 180, 1'b0);
        seg_add(1'b1, 200, 1'b0); seg_add(1'b0, 220, 1'b0);
        seg_add(1'b1, 180, 1'b0); run_trial("pulse180_220");

        seg_clear(); seg_add(1'b1, 221, 1'b0); seg_add(1'b0, 200, 1'b0);
        add_pulses(4, 200, 200, 1'b0); run_trial("pulse221");

        seg_clear(); seg_add(1'b1, 200, 1'b0); seg_add(1'b0, 221, 1'b0);
        add_pulses(4, 200, 200, 1'b0); run_trial("gap221");

        seg_clear(); seg_add(1'b1, 200, 1'b0); seg_add(1'b0, 100, 1'b0);
        add_pulses(4, 200, 200, 1'b0); run_trial("short_gap");

        en_test();
        rst_test();

        for (int t = 0; t < 8; t++) begin
            seg_clear();
            np = $urandom_range(2, 5);
            for (int p = 0; p < np; p++) begin
                pick_w(w, gl);
                seg_add(1'b1, w, gl);
                if (p < np - 1) begin
                    pick_w(w, gl);
                    seg_add(1'b0, w, gl);
                end
            end
            run_trial($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/packet_detector.md
# packet_detector

Front-end detector that sits directly upstream of the backscatter modulator and drives its DEC_IN input. It synchronises and deglitches the envelope-comparator output, validates a fixed preamble of high pulses and low gaps by measuring their widths in CLK cycles, and then holds DEC_OUT high for a programmable window. The modulator times its response window against that window. DEC_OUT's rising edge sits at a fixed latency after the last preamble pulse, so downstream count constants can absorb it.

## Interface
- FILT_LEN, 4: number of consecutive synchronised samples required to accept a level change (≥1).
- PULSE_MIN, 180: minimum accepted high-pulse width in cycles (9 µs at 50 ns/cycle).
- PULSE_MAX, 220: maximum accepted high-pulse width in cycles.
- GAP_MIN, 180: minimum accepted low-gap width in cycles.
- GAP_MAX, 220: maximum accepted low-gap width in cycles.
- NUM_PULSES, 4: number of valid pulses that make a preamble (≥1).
- HOLD_LEN, 1000: number of cycles DEC_OUT stays high after detection (≥1).
- CNT_W, 16: width counter bits; PULSE_MAX+1, GAP_MAX+1 and HOLD_LEN must all be < 2^CNT_W.
- CLK  in  1  system clock, 20 MHz (50 ns).
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  block enable; low = synchronous clear of FSM and outputs.
- COMP_IN  in  1  raw, asynchronous envelope-comparator output.
- DEC_OUT  out  1  packet window to the modulator's DEC_IN; registered.
- DET_STB  out  1  one-cycle strobe on the first cycle of DEC_OUT high.

## Operation
- Synchroniser: two flops s1→s2 on COMP_IN; always running, including while EN is low.
- Deglitch filter:
  - Filtered level `lvl` plus run counter `fc`; always running.
  - If s2 ≠ lvl, fc increments. When fc reaches FILT_LEN, lvl toggles and fc clears.
  - If s2 == lvl, fc clears.
- Edges: `rise` = lvl goes 0→1, `fall` = lvl goes 1→0, both taken from the registered previous lvl.
- FSM states: IDLE, HIGH, LOW, HOLD. Width counter `wc` (CNT_W bits), pulse counter `pc`.
  - IDLE: on rise → HIGH, wc=1, pc=0. Otherwise stay.
  - HIGH:
    - While lvl is high, wc increments.
    - If wc would exceed PULSE_MAX → IDLE (abort).
    - On fall with PULSE_MIN ≤ wc ≤ PULSE_MAX:
      - If pc+1 == NUM_PULSES → HOLD, wc=1.
      - Otherwise → LOW, pc+1, wc=1.
    - On fall with wc < PULSE_MIN → IDLE.
  - LOW:
    - While lvl is low, wc increments.
    - If wc would exceed GAP_MAX → IDLE.
    - On rise with GAP_MIN ≤ wc ≤ GAP_MAX → HIGH, wc=1.
    - On rise with wc < GAP_MIN → HIGH, wc=1, pc=0. The edge is treated as the first pulse of a new preamble.
  - HOLD:
    - lvl is ignored.
    - wc increments. When wc == HOLD_LEN → IDLE, wc=0, pc=0.
- Width semantics: wc at a fall or rise equals the number of cycles lvl was in the previous level.
- DEC_OUT = 1 exactly while state == HOLD, so it is high for exactly HOLD_LEN cycles.
- DET_STB = 1 on the IDLE/HIGH→HOLD transition cycle only.
- EN low:
  - Next edge: state IDLE, wc=0, pc=0, DEC_OUT=0, DET_STB=0.
  - Re-enabling waits for a fresh rise; a level already high at enable is not counted.
- RST high, asynchronous: s1, s2, lvl, fc, wc and pc clear to 0; state = IDLE; DEC_OUT=0; DET_STB=0.
- Precedence: RST > EN low > FSM.

## Timing
- COMP_IN to lvl: a level change first sampled by s1 at edge k appears on lvl at edge k+1+FILT_LEN.
- Filtered edge to FSM: the state update occurs at the following edge.
- Detection latency: from the first edge sampling the final preamble fall to DEC_OUT=1 is FILT_LEN+2 cycles (6 cycles = 300 ns by default). It is constant and independent of pulse widths.
- DEC_OUT falls exactly HOLD_LEN cycles after it rises, with no early termination except EN low or RST.
- Back-to-back packets: the cycle after HOLD ends, the FSM is in IDLE and accepts a rise. A rise that occurred during HOLD is not remembered.
- No handshake with the modulator: DEC_OUT is a level and the modulator self-times from its rising edge.

## Test plan
- Nominal preamble: 4 pulses of 200 high / 200 low on COMP_IN.
  - DEC_OUT rises 6 cycles after the 4th fall and stays high 1000 cycles.
  - DET_STB is high for exactly 1 cycle.
- Glitch rejection: 3-cycle high spikes and 3-cycle low dropouts inside 200-cycle pulses.
  - lvl never toggles on the spikes.
  - Detection and timing are identical to the nominal case.
- Width limits:
  - Pulse of 179 → no DEC_OUT.
  - Pulses of 180 and 220 → accepted.
  - Pulse of 221 → abort to IDLE at wc 221.
  - Gap of 221 → abort.
- Short gap restart:
  - Sequence 200H/100L/200H/200L/200H/200L/200H/200L/200H.
  - Detection completes on the 5th pulse, not the 4th.
- EN low for 1 cycle mid-HOLD (cycle 500) → DEC_OUT=0 on the next edge and remains 0 until a new full preamble.
- RST asserted asynchronously mid-LOW and mid-HOLD → DEC_OUT=0 without a clock edge.
  - After release, 2 pulses and then a full preamble → detection on the full preamble only.
